systolic_matmul_top: RTL and testbench
======================================

// Module: systolic_matmul_top
// PURPOSE
//  Tiled int matrix multiplier: C(m x p) = A(m x n) * B(n x p), mod 2^DATA_WIDTH.
//  Sits between a start/done control port and three req/ack memory buses (A read, B read, C write).
//  An ARRAY_HEIGHT x ARRAY_WIDTH output-stationary MAC array computes one C tile per pass.
// PARAMETERS
//  ARRAY_WIDTH       16  MAC columns (C tile width); must be <= BUS_WIDTH_BYTES
//  ARRAY_HEIGHT      16  MAC rows (C tile height); must be <= BUS_WIDTH_BYTES
//  DATA_WIDTH        8   element width in bits; accumulators are 32 bits
//  BUS_WIDTH_BYTES   32  bytes per bus beat
//  DATA_WIDTH_BYTES  1   bytes per element
// PORTS
//  clk            in   1    single clock, rising edge
//  reset          in   1    asynchronous, active-high reset
//  start_i        in   1    start pulse; sampled only in IDLE
//  m, n, p        in   16   dimensions; m multiple of ARRAY_HEIGHT, p multiple of ARRAY_WIDTH
//  base_addr_a/b/c in  16   byte base addresses
//  a_req/b_req    out  1    read request; a_addr/b_addr out 16; a_rdata/b_rdata in 8*BUS_WIDTH_BYTES
//  a_ack/b_ack    in   1    transfer completes on the edge where ack is sampled 1
//  c_req          out  1    write request; c_addr out 16; c_wdata out 8*BUS_WIDTH_BYTES
//  c_be           out  BUS_WIDTH_BYTES  byte enables; c_ack in 1
//  operation_done out  1    one-cycle pulse at end of operation
// BEHAVIOUR
//  - Layout: A column-major (a(i,k) @ base_a+k*m+i); B and C row-major (b(k,j) @ base_b+k*p+j).
//  - Bus beat: byte lane L of data = byte at addr+L. Element e occupies lanes e*DATA_WIDTH_BYTES+.
//  - Handshake: req/addr/wdata/be held stable until ack sampled 1.
//    req then drops for >=1 cycle, so each transfer is exactly one req rising edge.
//    New req only after ack is seen 0.
//  - FSM states:
//    - IDLE: start_i accepted, k/tile counters cleared.
//    - FETCH: A slice a(i0..i0+H-1,k) and B slice b(k,j0..j0+W-1) requested in parallel; wait for both acks.
//    - MAC: 1 cycle, acc[r][c] += a[r]*b[c] (signed).
//      k<n-1 -> k++ -> FETCH; else WRITE.
//    - WRITE: ARRAY_HEIGHT writes, row r to base_c+(i0+r)*p+j0.
//      wdata lanes hold acc[r][*] low DATA_WIDTH bits; c_be low W*DATA_WIDTH_BYTES bits set.
//      Then clear acc, advance tile (j0 fastest, then i0); FETCH, or DONE after the last tile.
//    - DONE: operation_done=1 for 1 cycle -> IDLE.
//  - Internal start_array pulses when the first FETCH begins.
//    Internal array_done pulses on the final MAC of the last tile.
//  - m==0, n==0 or p==0: no bus traffic; operation_done pulses 2 cycles after start_i.
//  - start_i while busy: ignored. Dimensions/bases latched at start.
//  - Reset (any time, incl. mid-op): all req=0, addr/data/be=0, operation_done=0, acc=0, FSM=IDLE.
//  - Request counts: a_req = b_req = (m/H)*(p/W)*n; c_req = m*(p/W).
// CONFIGURATION
//  PERF_CNT_EN defined: adds 32-bit outputs perf_cycles, perf_a_req, perf_b_req, perf_c_req.
//    All four clear on accepted start.
//    perf_cycles counts clocks from start_array to array_done; the others count req rising edges.
//  PERF_CNT_EN undefined: those ports and counters are absent; all else identical.
// TESTING
//  1. 16x16, m=n=p=16, A=I, b(k,j)=k+j -> C==B; a_req=16, b_req=16, c_req=16; one done pulse.
//  2. m=n=p=64, A,B all 1 -> every c=64 (0x40); a_req=b_req=1024, c_req=256.
//  3. m=n=p=32, a=2, b=200 -> c = 12800 mod 256 = 0x00. Verifies wrap. Signed: a=-1, b=3 -> c=0xA0.
//  4. n=0 -> no req on any bus; operation_done 2 cycles after start.
//  5. reset asserted mid-FETCH -> all req low same cycle; restart with case 1 passes.
//  6. ack delayed 5 cycles and start_i pulsed while busy -> results and counts as case 2; extra start ignored.

Source files
------------

// File: rtl/systolic_matmul_if.sv
// Memory-side bundle of the systolic matrix multiplier.
// Three independent req/ack buses:
//   A read  : a_req, a_addr -> a_rdata, a_ack
//   B read  : b_req, b_addr -> b_rdata, b_ack
//   C write : c_req, c_addr, c_wdata, c_be -> c_ack
// The multiplier is the master. A memory model or arbiter is the slave.
// A transfer completes on the clock edge where ack is sampled high.
interface systolic_matmul_if #(
    parameter int BUS_WIDTH_BYTES = 32
);
    logic                         a_req;
    logic [15:0]                  a_addr;
    logic [BUS_WIDTH_BYTES*8-1:0] a_rdata;
    logic                         a_ack;

    logic                         b_req;
    logic [15:0]                  b_addr;
    logic [BUS_WIDTH_BYTES*8-1:0] b_rdata;
    logic                         b_ack;

    logic                         c_req;
    logic [15:0]                  c_addr;
    logic [BUS_WIDTH_BYTES*8-1:0] c_wdata;
    logic [BUS_WIDTH_BYTES-1:0]   c_be;
    logic                         c_ack;

    modport master (
        output a_req, a_addr, b_req, b_addr, c_req, c_addr, c_wdata, c_be,
        input  a_rdata, a_ack, b_rdata, b_ack, c_ack
    );

    modport slave (
        input  a_req, a_addr, b_req, b_addr, c_req, c_addr, c_wdata, c_be,
        output a_rdata, a_ack, b_rdata, b_ack, c_ack
    );
endinterface

// File: rtl/systolic_matmul_top.sv
// Tiled integer matrix multiplier, C(m x p) = A(m x n) * B(n x p), mod 2^DATA_WIDTH.
// An ARRAY_HEIGHT x ARRAY_WIDTH output-stationary MAC array computes one C tile per pass.
// For each k, one A column slice and one B row slice are fetched in parallel.
// All products are then accumulated in a single cycle.
// After the last k, the tile is written out one row per bus write.
// Memory layout: A is column-major. B and C are row-major.
//
// Ports:
//   clk, reset          single clock; asynchronous active-high reset
//   start_i             start pulse, only honoured in IDLE
//   m, n, p             matrix dimensions, latched at start
//   base_addr_a/b/c     byte base addresses, latched at start
//   bus                 A/B read and C write req/ack buses (master side)
//   operation_done      one-cycle pulse when the operation has finished
//
// Optional feature, enabled by defining PERF_CNT_EN:
//   perf_cycles   clocks from the first fetch to the final MAC
//   perf_a_req    request count on the A bus
//   perf_b_req    request count on the B bus
//   perf_c_req    request count on the C bus
//   All four are 32-bit outputs and clear on an accepted start.
module systolic_matmul_top #(
    parameter int ARRAY_WIDTH      = 16,
    parameter int ARRAY_HEIGHT     = 16,
    parameter int DATA_WIDTH       = 8,
    parameter int BUS_WIDTH_BYTES  = 32,
    parameter int DATA_WIDTH_BYTES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [15:0] m,
    input  logic [15:0] n,
    input  logic [15:0] p,
    input  logic [15:0] base_addr_a,
    input  logic [15:0] base_addr_b,
    input  logic [15:0] base_addr_c,
    systolic_matmul_if.master bus,
    output logic        operation_done
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_a_req,
    output logic [31:0] perf_b_req,
    output logic [31:0] perf_c_req
`endif
);
    localparam int EW       = DATA_WIDTH_BYTES * 8;
    localparam int BUS_BITS = BUS_WIDTH_BYTES * 8;
    localparam int RW       = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
    localparam logic [BUS_WIDTH_BYTES-1:0] BE_MASK =
        {BUS_WIDTH_BYTES{1'b1}} >> (BUS_WIDTH_BYTES - ARRAY_WIDTH * DATA_WIDTH_BYTES);

    typedef enum logic [2:0] {IDLE, FETCH, MAC, WRITE, DONE} state_t;
    state_t state_reg, state_next;

    logic [15:0] m_reg, n_reg, p_reg, base_a_reg, base_b_reg, base_c_reg;
    logic [15:0] k_reg, i0_reg, j0_reg;
    logic [RW-1:0] row_reg;
    logic a_got_reg, b_got_reg;
    logic [ARRAY_HEIGHT*EW-1:0] a_buf_reg;
    logic [ARRAY_WIDTH*EW-1:0]  b_buf_reg;
    logic a_req_reg, b_req_reg, c_req_reg;
    logic [15:0] a_addr_reg, b_addr_reg, c_addr_reg;
    logic [BUS_BITS-1:0] c_wdata_reg, row_data;
    logic [BUS_WIDTH_BYTES-1:0] c_be_reg;
    logic operation_done_reg;
    logic [DATA_WIDTH-1:0] acc_low [ARRAY_HEIGHT][ARRAY_WIDTH];

    logic dims_zero, last_k, last_col, last_row, row_last;
    logic a_raise, a_take, b_raise, b_take, c_raise, c_take, tile_end;

    assign dims_zero = (m == 16'd0) || (n == 16'd0) || (p == 16'd0);
    assign last_k    = (k_reg == n_reg - 16'd1);
    assign last_col  = ({1'b0, j0_reg} + 17'(ARRAY_WIDTH)) >= {1'b0, p_reg};
    assign last_row  = ({1'b0, i0_reg} + 17'(ARRAY_HEIGHT)) >= {1'b0, m_reg};
    assign row_last  = (row_reg == RW'(ARRAY_HEIGHT - 1));

    // A request only rises once the previous ack has been seen low.
    // Each transfer is therefore exactly one req rising edge.
    assign a_raise  = (state_reg == FETCH) && !a_req_reg && !a_got_reg && !bus.a_ack;
    assign a_take   = (state_reg == FETCH) && a_req_reg && bus.a_ack;
    assign b_raise  = (state_reg == FETCH) && !b_req_reg && !b_got_reg && !bus.b_ack;
    assign b_take   = (state_reg == FETCH) && b_req_reg && bus.b_ack;
    assign c_raise  = (state_reg == WRITE) && !c_req_reg && !bus.c_ack;
    assign c_take   = (state_reg == WRITE) && c_req_reg && bus.c_ack;
    assign tile_end = c_take && row_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_i) state_next = dims_zero ? DONE : FETCH;
            FETCH:   if (a_got_reg && b_got_reg) state_next = MAC;
            MAC:     state_next = last_k ? WRITE : FETCH;
            WRITE:   if (tile_end) state_next = (last_row && last_col) ? DONE : FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lanes carry row row_reg of the tile; lanes past the tile width stay zero.
    always_comb begin
        row_data = '0;
        for (int c = 0; c < ARRAY_WIDTH; c++)
            row_data[c*EW +: DATA_WIDTH] = acc_low[row_reg][c];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_reg <= '0; n_reg <= '0; p_reg <= '0;
            base_a_reg <= '0; base_b_reg <= '0; base_c_reg <= '0;
            k_reg <= '0; i0_reg <= '0; j0_reg <= '0; row_reg <= '0;
            a_got_reg <= 1'b0; b_got_reg <= 1'b0;
            a_buf_reg <= '0; b_buf_reg <= '0;
            a_req_reg <= 1'b0; b_req_reg <= 1'b0; c_req_reg <= 1'b0;
            a_addr_reg <= '0; b_addr_reg <= '0; c_addr_reg <= '0;
            c_wdata_reg <= '0; c_be_reg <= '0;
            operation_done_reg <= 1'b0;
        end else begin
            operation_done_reg <= (state_reg == DONE);
            if ((state_reg == IDLE) && start_i) begin
                m_reg <= m; n_reg <= n; p_reg <= p;
                base_a_reg <= base_addr_a; base_b_reg <= base_addr_b; base_c_reg <= base_addr_c;
                k_reg <= '0; i0_reg <= '0; j0_reg <= '0; row_reg <= '0;
                a_got_reg <= 1'b0; b_got_reg <= 1'b0;
            end
            if (a_raise) begin
                a_req_reg  <= 1'b1;
                a_addr_reg <= base_a_reg + k_reg * m_reg + i0_reg;
            end else if (a_take) begin
                a_req_reg <= 1'b0;
                a_got_reg <= 1'b1;
                a_buf_reg <= bus.a_rdata[ARRAY_HEIGHT*EW-1:0];
            end
            if (b_raise) begin
                b_req_reg  <= 1'b1;
                b_addr_reg <= base_b_reg + k_reg * p_reg + j0_reg;
            end else if (b_take) begin
                b_req_reg <= 1'b0;
                b_got_reg <= 1'b1;
                b_buf_reg <= bus.b_rdata[ARRAY_WIDTH*EW-1:0];
            end
            if (state_reg == MAC) begin
                a_got_reg <= 1'b0;
                b_got_reg <= 1'b0;
                k_reg     <= last_k ? 16'd0 : k_reg + 16'd1;
            end
            if (c_raise) begin
                c_req_reg   <= 1'b1;
                c_addr_reg  <= base_c_reg + (i0_reg + 16'(row_reg)) * p_reg + j0_reg;
                c_wdata_reg <= row_data;
                c_be_reg    <= BE_MASK;
            end else if (c_take) begin
                c_req_reg <= 1'b0;
                if (row_last) begin
                    // Tiles advance along j0 first, then step down to the next i0.
                    row_reg <= '0;
                    if (last_col) begin
                        j0_reg <= '0;
                        i0_reg <= i0_reg + 16'(ARRAY_HEIGHT);
                    end else begin
                        j0_reg <= j0_reg + 16'(ARRAY_WIDTH);
                    end
                end else begin
                    row_reg <= row_reg + RW'(1);
                end
            end
        end
    end

    for (genvar gi = 0; gi < ARRAY_HEIGHT; gi++) begin : g_row
        for (genvar gj = 0; gj < ARRAY_WIDTH; gj++) begin : g_col
            logic signed [DATA_WIDTH-1:0] a_el, b_el;
            logic signed [31:0] prod, acc_reg;
            logic [31-DATA_WIDTH:0] acc_hi_unused;
            assign a_el = a_buf_reg[gi*EW +: DATA_WIDTH];
            assign b_el = b_buf_reg[gj*EW +: DATA_WIDTH];
            assign prod = 32'(a_el) * 32'(b_el);
            always_ff @(posedge clk or posedge reset) begin
                if (reset)                 acc_reg <= '0;
                else if (tile_end)         acc_reg <= '0;
                else if (state_reg == MAC) acc_reg <= acc_reg + prod;
            end
            assign acc_low[gi][gj] = acc_reg[DATA_WIDTH-1:0];
            // The full 32-bit sum is kept, but only the low element bits are ever written out.
            assign acc_hi_unused = acc_reg[31:DATA_WIDTH];
        end
    end

    assign bus.a_req   = a_req_reg;
    assign bus.a_addr  = a_addr_reg;
    assign bus.b_req   = b_req_reg;
    assign bus.b_addr  = b_addr_reg;
    assign bus.c_req   = c_req_reg;
    assign bus.c_addr  = c_addr_reg;
    assign bus.c_wdata = c_wdata_reg;
    assign bus.c_be    = c_be_reg;
    assign operation_done = operation_done_reg;

`ifdef PERF_CNT_EN
    logic start_array, array_done, perf_run_reg;
    logic [31:0] perf_cycles_reg, perf_a_reg, perf_b_reg, perf_c_reg;
    assign start_array = (state_reg == IDLE) && start_i && !dims_zero;
    assign array_done  = (state_reg == MAC) && last_k && last_row && last_col;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_run_reg <= 1'b0;
            perf_cycles_reg <= '0; perf_a_reg <= '0; perf_b_reg <= '0; perf_c_reg <= '0;
        end else if ((state_reg == IDLE) && start_i) begin
            perf_run_reg <= start_array;
            perf_cycles_reg <= '0; perf_a_reg <= '0; perf_b_reg <= '0; perf_c_reg <= '0;
        end else begin
            if (perf_run_reg) perf_cycles_reg <= perf_cycles_reg + 32'd1;
            if (array_done)   perf_run_reg <= 1'b0;
            if (a_raise)      perf_a_reg <= perf_a_reg + 32'd1;
            if (b_raise)      perf_b_reg <= perf_b_reg + 32'd1;
            if (c_raise)      perf_c_reg <= perf_c_reg + 32'd1;
        end
    end
    assign perf_cycles = perf_cycles_reg;
    assign perf_a_req  = perf_a_reg;
    assign perf_b_req  = perf_b_reg;
    assign perf_c_req  = perf_c_reg;
`endif
endmodule

// File: tb/tb_systolic_matmul_top.sv
module tb_systolic_matmul_top;
    localparam int H = 16;
    localparam int W = 16;
    localparam int BWB = 32;
    localparam int BUDGET = 30000;
    localparam logic [15:0] BASE_A = 16'h0000;
    localparam logic [15:0] BASE_B = 16'h2000;
    localparam logic [15:0] BASE_C = 16'h4000;

    logic clk = 1'b0;
    logic reset;
    logic start_i;
    logic [15:0] m, n, p;
    logic operation_done;
    always #5 clk = ~clk;

    systolic_matmul_if #(.BUS_WIDTH_BYTES(BWB)) bus ();
`ifdef PERF_CNT_EN
    logic [31:0] perf_cycles, perf_a_req, perf_b_req, perf_c_req;
`endif

    systolic_matmul_top #(
        .ARRAY_WIDTH(W), .ARRAY_HEIGHT(H), .DATA_WIDTH(8),
        .BUS_WIDTH_BYTES(BWB), .DATA_WIDTH_BYTES(1)
    ) dut (
        .clk(clk), .reset(reset), .start_i(start_i),
        .m(m), .n(n), .p(p),
        .base_addr_a(BASE_A), .base_addr_b(BASE_B), .base_addr_c(BASE_C),
        .bus(bus),
        .operation_done(operation_done)
`ifdef PERF_CNT_EN
        , .perf_cycles(perf_cycles), .perf_a_req(perf_a_req),
        .perf_b_req(perf_b_req), .perf_c_req(perf_c_req)
`endif
    );

    // Byte memories. A/B are written only by the main process.
    // C and its write tag are written only by the responder.
    logic [7:0] amem [65536];
    logic [7:0] bmem [65536];
    logic [7:0] cmem [65536];
    logic [7:0] cgen [65536];
    int ack_delay = 0;
    int vec_id = 0;

    // Bus responder: ack follows req after ack_delay idle cycles, held for one cycle.
    initial begin : responder
        int aw, bw, cw;
        aw = 0; bw = 0; cw = 0;
        bus.a_ack = 1'b0; bus.b_ack = 1'b0; bus.c_ack = 1'b0;
        bus.a_rdata = '0; bus.b_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.a_ack) bus.a_ack = 1'b0;
            else if (!bus.a_req) aw = 0;
            else if (aw < ack_delay) aw++;
            else begin
                aw = 0;
                for (int l = 0; l < BWB; l++) begin
                    logic [15:0] adr;
                    adr = bus.a_addr + 16'(l);
                    bus.a_rdata[l*8 +: 8] = amem[adr];
                end
                bus.a_ack = 1'b1;
            end
            if (bus.b_ack) bus.b_ack = 1'b0;
            else if (!bus.b_req) bw = 0;
            else if (bw < ack_delay) bw++;
            else begin
                bw = 0;
                for (int l = 0; l < BWB; l++) begin
                    logic [15:0] adr;
                    adr = bus.b_addr + 16'(l);
                    bus.b_rdata[l*8 +: 8] = bmem[adr];
                end
                bus.b_ack = 1'b1;
            end
            if (bus.c_ack) bus.c_ack = 1'b0;
            else if (!bus.c_req) cw = 0;
            else if (cw < ack_delay) cw++;
            else begin
                cw = 0;
                for (int l = 0; l < BWB; l++) begin
                    logic [15:0] adr;
                    adr = bus.c_addr + 16'(l);
                    if (bus.c_be[l]) begin
                        cmem[adr] = bus.c_wdata[l*8 +: 8];
                        cgen[adr] = 8'(vec_id);
                    end
                end
                bus.c_ack = 1'b1;
            end
        end
    end

    // Cumulative request rising edges and done-pulse cycles.
    logic a_prev = 1'b0, b_prev = 1'b0, c_prev = 1'b0;
    int a_cnt = 0, b_cnt = 0, c_cnt = 0, done_cnt = 0;
    always @(posedge clk) begin
        a_prev <= bus.a_req;
        b_prev <= bus.b_req;
        c_prev <= bus.c_req;
        if (bus.a_req && !a_prev) a_cnt <= a_cnt + 1;
        if (bus.b_req && !b_prev) b_cnt <= b_cnt + 1;
        if (bus.c_req && !c_prev) c_cnt <= c_cnt + 1;
        if (operation_done) done_cnt <= done_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // a_mode: 0 = constant a_val, 1 = identity.
    // b_mode: 0 = constant b_val, 1 = b(k,j)=k+j.
    // kind: 0 = every c equals cval, 1 = c(i,j)=i+j, 2 = no C write at all.
    typedef struct {
        string name;
        int m, n, p;
        int a_mode, a_val, b_mode, b_val;
        int delay, busy;
        int kind, cval;
        int ea, eb, ec;
        int lat;
    } vec_t;

    vec_t vecs [9];

    task automatic fill(input vec_t v);
        for (int i = 0; i < v.m; i++)
            for (int k = 0; k < v.n; k++) begin
                logic [15:0] adr;
                adr = BASE_A + 16'(k * v.m + i);
                amem[adr] = (v.a_mode == 1) ? ((i == k) ? 8'd1 : 8'd0) : 8'(v.a_val);
            end
        for (int k = 0; k < v.n; k++)
            for (int j = 0; j < v.p; j++) begin
                logic [15:0] adr;
                adr = BASE_B + 16'(k * v.p + j);
                bmem[adr] = (v.b_mode == 1) ? 8'(k + j) : 8'(v.b_val);
            end
        m = 16'(v.m); n = 16'(v.n); p = 16'(v.p);
        ack_delay = v.delay;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int a0, b0, c0, d0, cyc, bad;
        fill(v);
        vec_id = id;
        a0 = a_cnt; b0 = b_cnt; c0 = c_cnt; d0 = done_cnt;
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        cyc = 1;
        while (!operation_done && cyc < BUDGET) begin
            start_i = (v.busy != 0) && (cyc == 50 || cyc == 600);
            @(posedge clk); #1;
            cyc++;
        end
        start_i = 1'b0;
        check({v.name, " done_seen"}, operation_done, 1);
        if (v.lat > 0) check({v.name, " done_latency"}, cyc, v.lat);
        repeat (20) @(posedge clk);
        #1;
        check({v.name, " done_pulses"}, done_cnt - d0, 1);
        check({v.name, " a_req_count"}, a_cnt - a0, v.ea);
        check({v.name, " b_req_count"}, b_cnt - b0, v.eb);
        check({v.name, " c_req_count"}, c_cnt - c0, v.ec);
`ifdef PERF_CNT_EN
        check({v.name, " perf_a_req"}, perf_a_req, v.ea);
        check({v.name, " perf_b_req"}, perf_b_req, v.eb);
        check({v.name, " perf_c_req"}, perf_c_req, v.ec);
`endif
        bad = 0;
        for (int i = 0; i < v.m; i++)
            for (int j = 0; j < v.p; j++) begin
                logic [15:0] adr;
                int got, want;
                adr = BASE_C + 16'(i * v.p + j);
                got = (cgen[adr] == 8'(id)) ? int'(cmem[adr]) : -1;
                want = (v.kind == 0) ? v.cval : (v.kind == 1) ? ((i + j) & 255) : -1;
                if (got != want) begin
                    if (bad == 0)
                        $display("  first bad C(%0d,%0d) in %s: got %0d want %0d", i, j, v.name, got, want);
                    bad++;
                end
            end
        check({v.name, " c_data_bad_elems"}, bad, 0);
        $display("vec %s: m=%0d n=%0d p=%0d cycles=%0d a=%0d b=%0d c=%0d bad_c=%0d",
                 v.name, v.m, v.n, v.p, cyc, a_cnt - a0, b_cnt - b0, c_cnt - c0, bad);
    endtask

    initial begin : main
        int a0, cyc;
        vecs[0] = '{"ident16",    16, 16, 16, 1, 0,   1, 0,   0, 0, 1, 0,   16,   16,   16,  0};
        vecs[1] = '{"ones64",     64, 64, 64, 0, 1,   0, 1,   0, 0, 0, 64,  1024, 1024, 256, 0};
        vecs[2] = '{"wrap32",     32, 32, 32, 0, 2,   0, 200, 0, 0, 0, 0,   128,  128,  64,  0};
        vecs[3] = '{"signed32",   32, 32, 32, 0, 255, 0, 3,   1, 0, 0, 160, 128,  128,  64,  0};
        vecs[4] = '{"n_zero",     16, 0,  16, 0, 1,   0, 1,   0, 0, 2, 0,   0,    0,    0,   2};
        vecs[5] = '{"m_zero",     0,  16, 16, 0, 1,   0, 1,   0, 0, 2, 0,   0,    0,    0,   2};
        vecs[6] = '{"rect_n5",    32, 5,  16, 0, 1,   0, 1,   2, 0, 0, 5,   10,   10,   32,  0};
        vecs[7] = '{"ident_p32",  16, 16, 32, 1, 0,   1, 0,   0, 0, 1, 0,   32,   32,   32,  0};
        vecs[8] = '{"slow_busy64", 64, 64, 64, 0, 1,  0, 1,   5, 1, 0, 64,  1024, 1024, 256, 0};

        reset = 1'b1; start_i = 1'b0; m = '0; n = '0; p = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst a_req", bus.a_req, 0);
        check("rst b_req", bus.b_req, 0);
        check("rst c_req", bus.c_req, 0);
        check("rst a_addr", bus.a_addr, 0);
        check("rst b_addr", bus.b_addr, 0);
        check("rst c_addr", bus.c_addr, 0);
        check("rst c_wdata_nonzero", bus.c_wdata != '0, 0);
        check("rst c_be", bus.c_be, 0);
        check("rst operation_done", operation_done, 0);
        reset = 1'b0;

        for (int vi = 0; vi < 9; vi++) run_vec(vecs[vi], vi + 1);

        // Reset in the middle of a fetch, then a clean rerun of the identity case.
        fill(vecs[0]);
        vec_id = 100;
        a0 = a_cnt;
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        cyc = 0;
        while (!(bus.a_req && (a_cnt - a0) >= 3) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("midfetch reached_a_req", bus.a_req, 1);
        #2 reset = 1'b1;
        #1;
        check("midfetch a_req", bus.a_req, 0);
        check("midfetch b_req", bus.b_req, 0);
        check("midfetch c_req", bus.c_req, 0);
        check("midfetch a_addr", bus.a_addr, 0);
        check("midfetch b_addr", bus.b_addr, 0);
        check("midfetch operation_done", operation_done, 0);
        $display("vec midfetch_reset: reset applied after %0d A requests", a_cnt - a0);
        @(posedge clk); #1 reset = 1'b0;
        run_vec(vecs[0], 101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
